drv_segment_scan: RTL and testbench
===================================

Name: drv_segment_scan

Overview:
- Time-multiplexed scan controller for a p_width-digit common-bus 7-segment display (decimal, unsigned).
- Drives one shared segment bus through a single drv_segment_dec, plus one-hot digit enables with dead-time blanking between digits.
- A double-buffered valid/ready load port applies new values only at frame boundaries, so no frame ever shows a mix of old and new digits.
- Sits between application logic (score/counter values) and the board display pins.

Parameters:
- p_width, 4, number of digits; must be ≥2.
- p_clk_div, 50000, clock cycles per digit slot; must be > p_blank.
- p_blank, 500, dead-time cycles at the start of each slot, with all digits off; must be ≥1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_value  input  [3:0] x [p_width-1:0] (unpacked)  BCD digits; index 0 is the least significant digit.
- i_valid  input  1  i_value is presented for loading.
- o_ready  output  1  pending buffer is empty; a load is accepted on a clock edge where i_valid & o_ready.
- i_lzb  input  1  leading-zero blanking enable; sampled per slot.
- o_drv_sgmnt  output  7  shared segment bus, active-high, standard team bit map (0 top, 1 upper-right … 6 middle).
- o_drv_digit  output  p_width  one-hot digit enable, active-high.
- o_frame  output  1  one-cycle pulse, registered, marking a frame boundary.

Behaviour:
- Reset, asynchronous while i_rst_n=0:
  - Outputs: o_drv_sgmnt=0, o_drv_digit=0, o_frame=0, o_ready=1.
  - Internal: slot counter cnt=0, digit index idx=0, display register=all 0, pending buffer empty, state BLANK.
- Slot counter: cnt runs 0..p_clk_div-1. At terminal count it wraps to 0 and idx advances; idx wraps from p_width-1 to 0.
- State machine (two states, derived from cnt):
  - BLANK (cnt < p_blank): o_drv_digit=0, o_drv_sgmnt=0.
  - SHOW (cnt ≥ p_blank): o_drv_digit = one-hot(idx); o_drv_sgmnt = decode(display[idx]) unless that digit is blanked.
- Output timing:
  - All outputs are registered, so they reflect state one cycle later.
  - Each digit is lit for exactly p_clk_div−p_blank consecutive cycles and dark for p_blank cycles before it.
  - Frame period is p_width·p_clk_div cycles.
- Frame boundary: the cycle with idx=p_width-1 and cnt=p_clk_div-1.
  - o_frame=1 on the following cycle.
  - If the pending buffer is full, it is copied to the display register at this boundary. The pending buffer empties and o_ready=1 from the next cycle.
- Load handshake:
  - On accept, i_value is captured into the pending buffer and o_ready=0 from the next cycle.
  - i_valid while o_ready=0 is ignored; the holder must keep it asserted.
  - No bypass: a value accepted on the boundary cycle itself (pending was empty) is displayed from the frame after next.
- Leading-zero blanking (i_lzb=1): digit k is blanked (segments 0, enable still asserted) if display[j]=0 for all j ≥ k, with k ≥ 1. Digit 0 is never blanked, so value 0000 shows "   0".
- Codes 10..15: whatever drv_segment_dec produces; the controller does not filter them.
- Reset mid-frame: immediate return to reset values. A pending load is discarded.
- No combinational path from any input to any output, including o_ready.

Decomposition:
- Shared package drv_segment_pkg:
  - typedef t_bcd (logic [3:0]);
  - typedef t_sgmnt (logic [6:0]);
  - constant SGMNT_OFF = 7'h00.
- Local enum {BLANK, SHOW} inside the module.
- Sub-module: reuse the existing drv_segment_dec (one instance, fed by the display-register mux at idx). No new sub-module.

Test Plan (p_width=4, p_clk_div=8, p_blank=2):
- Reset released, no load:
  - o_drv_digit cycles 0001→0010→0100→1000, each high 6 cycles with 2 cycles of 0000 before it.
  - o_drv_sgmnt = decode(0) while each digit is lit.
  - o_frame pulses every 32 cycles.
- Load {1,2,3,4} (digit3..0) mid-frame 0:
  - o_ready drops next cycle.
  - Frame 0 still shows 0s; from frame 1, digit0 shows 4 … digit3 shows 1.
  - o_ready returns 1 the cycle o_frame pulses.
- Second i_valid held while o_ready=0 with {9,9,9,9}:
  - Not accepted until o_ready=1, then accepted on that edge.
  - The display changes at the following boundary; no frame mixes the two values.
- Load asserted exactly on the boundary cycle with pending empty: value appears one full frame later (frame after next).
- i_lzb=1 with {0,0,5,0}: digits 3 and 2 show segments 0 (enables still pulse), digit1 shows 5, digit0 shows 0.
  - With {0,0,0,0}, only digit0 shows 0.
- Assert i_rst_n=0 mid-SHOW with a pending load:
  - Outputs go to 0 immediately (asynchronously), o_ready=1.
  - After release, zeros are displayed and the pending value is never shown.

Source files
------------

// File: rtl/drv_segment_pkg.sv
// Shared types and constants for the 7-segment display drivers.
//   t_bcd      : one BCD digit (codes 10..15 are passed through to the decoder)
//   t_sgmnt    : segment vector, bit 0 top, 1 upper-right, 2 lower-right,
//                3 bottom, 4 lower-left, 5 upper-left, 6 middle; active-high
//   SGMNT_OFF  : all segments dark
package drv_segment_pkg;

    typedef logic [3:0] t_bcd;
    typedef logic [6:0] t_sgmnt;

    localparam t_sgmnt SGMNT_OFF = 7'h00;

endpackage : drv_segment_pkg

// File: rtl/drv_segment_scan_if.sv
// Load port and display pins of the segment scan controller.
//   i_value     : BCD digits, index 0 least significant
//   i_valid     : i_value offered for loading
//   o_ready     : pending buffer empty, load accepted on i_valid & o_ready
//   i_lzb       : leading-zero blanking enable
//   o_drv_sgmnt : shared segment bus
//   o_drv_digit : one-hot digit enable
//   o_frame     : one-cycle frame boundary pulse
// master = application side, slave = controller side.
interface drv_segment_scan_if
    import drv_segment_pkg::*;
#(
    parameter int p_width = 4
) ();

    t_bcd               i_value [p_width];
    logic               i_valid;
    logic               o_ready;
    logic               i_lzb;
    t_sgmnt             o_drv_sgmnt;
    logic [p_width-1:0] o_drv_digit;
    logic               o_frame;

    modport master (
        output i_value,
        output i_valid,
        output i_lzb,
        input  o_ready,
        input  o_drv_sgmnt,
        input  o_drv_digit,
        input  o_frame
    );

    modport slave (
        input  i_value,
        input  i_valid,
        input  i_lzb,
        output o_ready,
        output o_drv_sgmnt,
        output o_drv_digit,
        output o_frame
    );

endinterface : drv_segment_scan_if

// File: rtl/drv_segment_dec.sv
// BCD to 7-segment decoder (purely combinational).
//   i_bcd   : digit code 0..15; 10..15 show hex glyphs A b C d E F
//   o_sgmnt : active-high segments, bit 0 top ... bit 6 middle
module drv_segment_dec
    import drv_segment_pkg::*;
(
    input  t_bcd   i_bcd,
    output t_sgmnt o_sgmnt
);

    // Glyph lookup
    always_comb begin
        o_sgmnt = SGMNT_OFF;
        case (i_bcd)
            4'd0:    o_sgmnt = 7'h3F;
            4'd1:    o_sgmnt = 7'h06;
            4'd2:    o_sgmnt = 7'h5B;
            4'd3:    o_sgmnt = 7'h4F;
            4'd4:    o_sgmnt = 7'h66;
            4'd5:    o_sgmnt = 7'h6D;
            4'd6:    o_sgmnt = 7'h7D;
            4'd7:    o_sgmnt = 7'h07;
            4'd8:    o_sgmnt = 7'h7F;
            4'd9:    o_sgmnt = 7'h6F;
            4'd10:   o_sgmnt = 7'h77;
            4'd11:   o_sgmnt = 7'h7C;
            4'd12:   o_sgmnt = 7'h39;
            4'd13:   o_sgmnt = 7'h5E;
            4'd14:   o_sgmnt = 7'h79;
            4'd15:   o_sgmnt = 7'h71;
            default: o_sgmnt = SGMNT_OFF;
        endcase
    end

endmodule : drv_segment_dec

// File: rtl/drv_segment_scan.sv
// Time-multiplexed scan controller for a p_width-digit common-bus 7-segment
// display. Each digit owns a slot of p_clk_div cycles; the first p_blank
// cycles of every slot keep all digits dark (dead time). New values enter a
// pending buffer through a valid/ready handshake and are copied to the
// display register only at the frame boundary, so a frame never mixes values.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : load port and display pins (drv_segment_scan_if.slave)
// All outputs, including o_ready, come straight from flops.
module drv_segment_scan
    import drv_segment_pkg::*;
#(
    parameter int p_width   = 4,
    parameter int p_clk_div = 50000,
    parameter int p_blank   = 500
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    drv_segment_scan_if.slave  bus
);

    localparam int CNT_W = $clog2(p_clk_div);
    localparam int IDX_W = $clog2(p_width);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(p_clk_div - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(p_blank);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(p_width - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } t_state;

    // Slot timing and scan state
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    t_state             r_state;

    // Display double buffer
    t_bcd               r_disp [p_width];
    t_bcd               r_pend [p_width];
    logic               r_pend_empty;
    logic               r_lzb;

    // Registered pins
    t_sgmnt             r_sgmnt;
    logic [p_width-1:0] r_digit;
    logic               r_frame;

    logic               w_slot_end;
    logic               w_boundary;
    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_nxt;
    t_bcd               w_cur_bcd;
    t_sgmnt             w_dec_sgmnt;
    logic [p_width-1:0] w_lead_zero;
    logic               w_zero_run;
    logic               w_blank;
    logic [p_width-1:0] w_onehot;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
    assign w_accept   = bus.i_valid && r_pend_empty;
    assign w_cnt_nxt  = w_slot_end ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
    assign w_cur_bcd  = r_disp[r_idx];
    assign w_onehot   = {{(p_width-1){1'b0}}, 1'b1} << r_idx;

    drv_segment_dec u_dec (
        .i_bcd   (w_cur_bcd),
        .o_sgmnt (w_dec_sgmnt)
    );

    // Leading-zero map: bit k set when every digit at or above k is zero
    always_comb begin
        w_zero_run  = 1'b1;
        w_lead_zero = {p_width{1'b0}};
        for (int k = p_width - 1; k >= 0; k--) begin
            w_zero_run     = w_zero_run & (r_disp[k] == 4'd0);
            w_lead_zero[k] = w_zero_run;
        end
    end

    // Digit 0 is never blanked, so an all-zero value still shows a single 0
    assign w_blank = r_lzb && (r_idx != {IDX_W{1'b0}}) && w_lead_zero[r_idx];

    // Scan FSM: slot counter, digit index, BLANK/SHOW state and the output pins.
    // r_state always describes the current r_cnt, so the pins lag it by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_state <= BLANK;
            r_sgmnt <= SGMNT_OFF;
            r_digit <= {p_width{1'b0}};
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= (w_cnt_nxt < BLANK_END) ? BLANK : SHOW;
            if (w_slot_end) begin
                r_idx <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1));
            end
            r_frame <= w_boundary;
            case (r_state)
                BLANK: begin
                    r_digit <= {p_width{1'b0}};
                    r_sgmnt <= SGMNT_OFF;
                end
                SHOW: begin
                    r_digit <= w_onehot;
                    r_sgmnt <= w_blank ? SGMNT_OFF : w_dec_sgmnt;
                end
                default: begin
                    r_digit <= {p_width{1'b0}};
                    r_sgmnt <= SGMNT_OFF;
                end
            endcase
        end
    end

    // Double buffer: capture on handshake, promote to display at frame boundary.
    // Accept needs an empty buffer and promotion a full one, so they never coincide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_empty <= 1'b1;
            for (int k = 0; k < p_width; k++) begin
                r_disp[k] <= 4'd0;
                r_pend[k] <= 4'd0;
            end
        end else if (w_accept) begin
            r_pend_empty <= 1'b0;
            for (int k = 0; k < p_width; k++) begin
                r_pend[k] <= bus.i_value[k];
            end
        end else if (w_boundary && !r_pend_empty) begin
            r_pend_empty <= 1'b1;
            for (int k = 0; k < p_width; k++) begin
                r_disp[k] <= r_pend[k];
            end
        end
    end

    // Blanking enable is latched at slot end so a digit is never half-blanked
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lzb <= 1'b0;
        end else if (w_slot_end) begin
            r_lzb <= bus.i_lzb;
        end
    end

    assign bus.o_ready     = r_pend_empty;
    assign bus.o_drv_sgmnt = r_sgmnt;
    assign bus.o_drv_digit = r_digit;
    assign bus.o_frame     = r_frame;

endmodule : drv_segment_scan

// File: tb/tb_drv_segment_scan.sv
// Directed bench for drv_segment_scan with p_width=4, p_clk_div=8, p_blank=2.
// The stimulus pushes the digits each frame must show into a queue; a monitor
// pops one entry per frame and checks every output cycle of that frame.
module tb_drv_segment_scan;

    localparam int W   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FRM = W * DIV;

    typedef struct packed {
        logic            lzb;
        logic [3:0][3:0] d;
    } frame_t;

    logic   clk;
    logic   rst_n;
    int     checks;
    int     errors;
    int     edges;
    frame_t sb_q [$];

    drv_segment_scan_if #(.p_width(W)) bus ();

    drv_segment_scan #(
        .p_width   (W),
        .p_clk_div (DIV),
        .p_blank   (BLK)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_tab(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] exp_seg(input frame_t f, input int k);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = k; j < W; j++) begin
            if (f.d[j] != 4'd0) all_zero = 1'b0;
        end
        if (f.lzb && (k >= 1) && all_zero) return 7'h00;
        return seg_tab(f.d[k]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        edges += n;
    endtask

    task automatic load(input logic [15:0] v);
        for (int k = 0; k < W; k++) bus.i_value[k] = v[4*k +: 4];
        bus.i_valid = 1'b1;
    endtask

    task automatic push_frame(input logic [15:0] v, input logic lzb);
        frame_t f;
        f.lzb = lzb;
        f.d   = v;
        sb_q.push_back(f);
    endtask

    // Monitor: checks pins once per cycle, frame by frame, against the queue
    initial begin
        int         t;
        int         slot;
        int         c;
        frame_t     cur;
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        t   = 0;
        cur = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                t = 0;
                check("rst_digit", 32'(bus.o_drv_digit), 32'd0);
                check("rst_sgmnt", 32'(bus.o_drv_sgmnt), 32'd0);
                check("rst_frame", 32'(bus.o_frame), 32'd0);
                check("rst_ready", 32'(bus.o_ready), 32'd1);
            end else begin
                t++;
                if (t == 1) begin
                    check("sb_avail", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) cur = sb_q.pop_front();
                end
                slot  = (t - 1) / DIV;
                c     = (t - 1) % DIV;
                e_dig = (c >= BLK) ? (4'b0001 << slot) : 4'b0000;
                e_seg = (c >= BLK) ? exp_seg(cur, slot) : 7'h00;
                check("digit", 32'(bus.o_drv_digit), 32'(e_dig));
                check("sgmnt", 32'(bus.o_drv_sgmnt), 32'(e_seg));
                check("frame", 32'(bus.o_frame), 32'(t == FRM));
                if (t == FRM) t = 0;
            end
        end
    end

    // Directed stimulus
    initial begin
        int guard;
        checks = 0;
        errors = 0;
        edges  = 0;
        rst_n  = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_lzb   = 1'b0;
        for (int k = 0; k < W; k++) bus.i_value[k] = 4'd0;
        #2 rst_n = 1'b0;
        push_frame(16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        edges = 0;

        // First load mid-frame 0, shown from frame 1
        step(10);
        check("ready_idle", 32'(bus.o_ready), 32'd1);
        load(16'h1234);
        push_frame(16'h1234, 1'b0);
        step(1);
        bus.i_valid = 1'b0;
        check("ready_drop", 32'(bus.o_ready), 32'd0);

        // Second value held while busy: taken on the edge after ready returns
        step(1);
        load(16'h9999);
        push_frame(16'h9999, 1'b0);
        guard = 0;
        while ((bus.o_ready !== 1'b1) && (guard < 2 * FRM)) begin
            step(1);
            guard++;
        end
        check("ready_return_edge", 32'(edges), 32'd32);
        check("ready_with_frame", 32'(bus.o_frame), 32'd1);
        step(1);
        bus.i_valid = 1'b0;
        check("held_accepted", 32'(bus.o_ready), 32'd0);

        // Load on the boundary cycle itself: shown from the frame after next
        step(95 - 33);
        check("bnd_ready", 32'(bus.o_ready), 32'd1);
        load(16'h5678);
        push_frame(16'h9999, 1'b0);
        push_frame(16'h5678, 1'b0);
        step(1);
        bus.i_valid = 1'b0;
        check("bnd_frame", 32'(bus.o_frame), 32'd1);
        check("bnd_ready_drop", 32'(bus.o_ready), 32'd0);

        // Leading-zero blanking with 0050, then 0000
        step(135 - 96);
        load(16'h0050);
        push_frame(16'h0050, 1'b1);
        step(1);
        bus.i_valid = 1'b0;
        step(156 - 136);
        bus.i_lzb = 1'b1;
        step(170 - 156);
        load(16'h0000);
        push_frame(16'h0000, 1'b1);
        push_frame(16'h0000, 1'b1);
        step(1);
        bus.i_valid = 1'b0;

        // Reset mid-SHOW with a pending load that must never appear
        step(230 - 171);
        load(16'h7777);
        step(1);
        bus.i_valid = 1'b0;
        check("pend_full", 32'(bus.o_ready), 32'd0);
        step(236 - 231);
        check("pre_rst_digit", 32'(bus.o_drv_digit), 32'h2);
        rst_n     = 1'b0;
        bus.i_lzb = 1'b0;
        #1;
        check("async_digit", 32'(bus.o_drv_digit), 32'd0);
        check("async_sgmnt", 32'(bus.o_drv_sgmnt), 32'd0);
        check("async_frame", 32'(bus.o_frame), 32'd0);
        check("async_ready", 32'(bus.o_ready), 32'd1);
        push_frame(16'h0000, 1'b0);
        push_frame(16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        step(2 * FRM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_drv_segment_scan
